// File: rtl/quant_packer.sv
// rtl/quant_packer.sv - packs variable-width requantized samples into 16-bit words behind a FWFT FIFO
module quant_packer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  Nquant,
  input  logic [17:0] datain,
  input  logic        endatain,
  input  logic        flush,
  output logic [15:0] dataout,
  output logic        dataout_valid,
  input  logic        dataout_ready,
  output logic        overflow
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] C_DEPTH = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic {ST_ACCUM, ST_FLUSH_PEND} state_t;

  state_t       r_state;
  logic [47:0]  r_acc;
  logic [5:0]   r_bitcnt;
  logic         r_overflow;

  logic [15:0]  r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]  r_count;

  logic [4:0]   w_n;
  logic [17:0]  w_din_mask;
  logic         w_app;
  logic         w_pop;
  logic         w_can_push;
  logic         w_drain;
  logic         w_pad;
  logic         w_push;
  logic [5:0]   w_after;
  logic [6:0]   w_sum;
  logic         w_take;
  logic [5:0]   w_cnt_next;
  logic [15:0]  w_drain_word;
  logic [15:0]  w_pad_word;
  logic [15:0]  w_push_word;

  // Widths above 18 saturate; zero width turns the strobe into a no-op.
  always_comb begin
    w_n = Nquant;
    if (Nquant > 5'd18) begin
      w_n = 5'd18;
    end
  end

  assign w_din_mask = datain & (18'h3FFFF >> (5'd18 - w_n));
  assign w_app      = endatain && (w_n != 5'd0);

  assign w_pop      = (r_count != '0) && dataout_ready;
  assign w_can_push = (r_count != C_DEPTH) || w_pop;

  assign w_drain    = (r_bitcnt >= 6'd16) && w_can_push;
  assign w_after    = r_bitcnt - (w_drain ? 6'd16 : 6'd0);
  assign w_sum      = {1'b0, w_after} + {2'b00, w_n};
  assign w_take     = w_app && (w_sum <= 7'd48);

  // Padding only fires on a strobe-free cycle so a coincident sample is never split.
  assign w_pad      = (r_state == ST_FLUSH_PEND) && (r_bitcnt != 6'd0) &&
                      (r_bitcnt < 6'd16) && !endatain && w_can_push;
  assign w_push     = w_drain || w_pad;

  assign w_cnt_next = w_pad ? 6'd0 : (w_take ? w_sum[5:0] : w_after);

  // Oldest unsent bit sits at acc[bitcnt-1]; bits above it are stale and ignored.
  assign w_drain_word = 16'(r_acc >> (r_bitcnt - 6'd16));
  assign w_pad_word   = 16'(r_acc << (6'd16 - r_bitcnt));
  assign w_push_word  = w_drain ? w_drain_word : w_pad_word;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_ACCUM;
      r_acc      <= '0;
      r_bitcnt   <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_bitcnt <= w_cnt_next;
      if (w_take) begin
        r_acc <= (r_acc << w_n) | {30'b0, w_din_mask};
      end
      if (w_app && !w_take) begin
        r_overflow <= 1'b1;
      end
      case (r_state)
        ST_ACCUM: begin
          if (flush && (w_cnt_next != 6'd0)) begin
            r_state <= ST_FLUSH_PEND;
          end
        end
        ST_FLUSH_PEND: begin
          if (w_cnt_next == 6'd0) begin
            r_state <= ST_ACCUM;
          end
        end
        default: r_state <= ST_ACCUM;
      endcase
    end
  end

  // Full FIFO may still accept a word when the head leaves in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= w_push_word;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign dataout_valid = (r_count != '0);
  assign dataout       = dataout_valid ? r_mem[r_rptr] : 16'h0000;
  assign overflow      = r_overflow;

endmodule
